// File: rtl/voice_allocator.sv
// Polyphonic MIDI voice allocator: scans the voice bank once per event,
// then retriggers, fills a free voice, or steals the oldest releasing or active voice.
module voice_allocator #(
    parameter int NUM_VOICES     = 4,
    parameter int RELEASE_CYCLES = 48000,
    parameter int AGE_BITS       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    note_valid,
    output logic                    note_ready,
    input  logic                    note_on,
    input  logic [6:0]              note_number,
    input  logic                    all_notes_off,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [8*NUM_VOICES-1:0] voice_note,
    output logic                    busy
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_W = $clog2(RELEASE_CYCLES + 1);
    localparam logic [AGE_BITS-1:0] AGE_MAX  = '1;
    localparam logic [CNT_W-1:0]    REL_INIT = CNT_W'(RELEASE_CYCLES);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT, S_GATE} fsm_e;
    typedef enum logic [1:0] {V_FREE, V_ACTIVE, V_RELEASE} voice_e;

    fsm_e                state_q, state_d;
    logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;
    logic [IDX_W-1:0]    tgt_idx_q, tgt_idx_d;
    logic                ev_on_q, ev_on_d;
    logic [6:0]          ev_note_q, ev_note_d;

    logic                match_found_q, match_found_d;
    logic [IDX_W-1:0]    match_idx_q, match_idx_d;
    logic                free_found_q, free_found_d;
    logic [IDX_W-1:0]    free_idx_q, free_idx_d;
    logic                rel_found_q, rel_found_d;
    logic [IDX_W-1:0]    rel_idx_q, rel_idx_d;
    logic [AGE_BITS-1:0] rel_age_q, rel_age_d;
    logic                act_found_q, act_found_d;
    logic [IDX_W-1:0]    act_idx_q, act_idx_d;
    logic [AGE_BITS-1:0] act_age_q, act_age_d;

    voice_e              vstate_q [NUM_VOICES];
    voice_e              vstate_d [NUM_VOICES];
    logic [6:0]          vnote_q  [NUM_VOICES];
    logic [6:0]          vnote_d  [NUM_VOICES];
    logic [AGE_BITS-1:0] age_q    [NUM_VOICES];
    logic [AGE_BITS-1:0] age_d    [NUM_VOICES];
    logic [CNT_W-1:0]    cnt_q    [NUM_VOICES];
    logic [CNT_W-1:0]    cnt_d    [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_q, gate_d;

    voice_e              cur_state;
    logic [6:0]          cur_note;
    logic [AGE_BITS-1:0] cur_age;
    logic [IDX_W-1:0]    commit_idx;

    assign cur_state = vstate_q[scan_idx_q];
    assign cur_note  = vnote_q[scan_idx_q];
    assign cur_age   = age_q[scan_idx_q];

    // Note-on priority: retrigger, then free voice, then oldest releasing, then oldest active.
    always_comb begin
        if (match_found_q)     commit_idx = match_idx_q;
        else if (free_found_q) commit_idx = free_idx_q;
        else if (rel_found_q)  commit_idx = rel_idx_q;
        else                   commit_idx = act_idx_q;
    end

    assign note_ready = (state_q == S_IDLE) && !all_notes_off && !rst;
    assign busy       = (state_q != S_IDLE);
    assign voice_gate = gate_q;

    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note[8*i +: 8] = {1'b0, vnote_q[i]};
        end
    end

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d       = state_q;
        scan_idx_d    = scan_idx_q;
        tgt_idx_d     = tgt_idx_q;
        ev_on_d       = ev_on_q;
        ev_note_d     = ev_note_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        rel_found_d   = rel_found_q;
        rel_idx_d     = rel_idx_q;
        rel_age_d     = rel_age_q;
        act_found_d   = act_found_q;
        act_idx_d     = act_idx_q;
        act_age_d     = act_age_q;
        vstate_d      = vstate_q;
        vnote_d       = vnote_q;
        age_d         = age_q;
        cnt_d         = cnt_q;
        gate_d        = gate_q;

        for (int i = 0; i < NUM_VOICES; i++) begin
            if (vstate_q[i] != V_FREE && age_q[i] != AGE_MAX) begin
                age_d[i] = age_q[i] + 1'b1;
            end
            if (vstate_q[i] == V_RELEASE) begin
                if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
                if (cnt_q[i] <= CNT_W'(1)) vstate_d[i] = V_FREE;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (all_notes_off) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (vstate_q[i] == V_ACTIVE) begin
                            vstate_d[i] = V_RELEASE;
                            gate_d[i]   = 1'b0;
                            cnt_d[i]    = REL_INIT;
                        end
                    end
                end else if (note_valid) begin
                    ev_on_d       = note_on;
                    ev_note_d     = note_number;
                    scan_idx_d    = '0;
                    match_found_d = 1'b0;
                    free_found_d  = 1'b0;
                    rel_found_d   = 1'b0;
                    act_found_d   = 1'b0;
                    state_d       = S_SCAN;
                end
            end

            S_SCAN: begin
                if (!match_found_q && cur_note == ev_note_q &&
                    (cur_state == V_ACTIVE || (ev_on_q && cur_state == V_RELEASE))) begin
                    match_found_d = 1'b1;
                    match_idx_d   = scan_idx_q;
                end
                if (!free_found_q && cur_state == V_FREE) begin
                    free_found_d = 1'b1;
                    free_idx_d   = scan_idx_q;
                end
                // Strictly-greater compare keeps the lowest index on age ties.
                if (cur_state == V_RELEASE && (!rel_found_q || cur_age > rel_age_q)) begin
                    rel_found_d = 1'b1;
                    rel_idx_d   = scan_idx_q;
                    rel_age_d   = cur_age;
                end
                if (cur_state == V_ACTIVE && (!act_found_q || cur_age > act_age_q)) begin
                    act_found_d = 1'b1;
                    act_idx_d   = scan_idx_q;
                    act_age_d   = cur_age;
                end
                if (scan_idx_q == LAST_IDX) state_d = S_COMMIT;
                else                        scan_idx_d = scan_idx_q + 1'b1;
            end

            S_COMMIT: begin
                if (ev_on_q) begin
                    // Gate is held low for one cycle so the envelope sees a fresh rising edge.
                    vstate_d[commit_idx] = V_ACTIVE;
                    vnote_d[commit_idx]  = ev_note_q;
                    gate_d[commit_idx]   = 1'b0;
                    age_d[commit_idx]    = '0;
                    cnt_d[commit_idx]    = '0;
                    tgt_idx_d            = commit_idx;
                    state_d              = S_GATE;
                end else begin
                    if (match_found_q) begin
                        vstate_d[match_idx_q] = V_RELEASE;
                        gate_d[match_idx_q]   = 1'b0;
                        cnt_d[match_idx_q]    = REL_INIT;
                    end
                    state_d = S_IDLE;
                end
            end

            S_GATE: begin
                gate_d[tgt_idx_q] = 1'b1;
                state_d           = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            scan_idx_q    <= '0;
            tgt_idx_q     <= '0;
            ev_on_q       <= 1'b0;
            ev_note_q     <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            rel_found_q   <= 1'b0;
            rel_idx_q     <= '0;
            rel_age_q     <= '0;
            act_found_q   <= 1'b0;
            act_idx_q     <= '0;
            act_age_q     <= '0;
            gate_q        <= '0;
            // NOTE: the per-voice arrays are small register files driving outputs, so each entry is reset.
            for (int i = 0; i < NUM_VOICES; i++) begin
                vstate_q[i] <= V_FREE;
                vnote_q[i]  <= '0;
                age_q[i]    <= AGE_MAX;
                cnt_q[i]    <= '0;
            end
        end else begin
            state_q       <= state_d;
            scan_idx_q    <= scan_idx_d;
            tgt_idx_q     <= tgt_idx_d;
            ev_on_q       <= ev_on_d;
            ev_note_q     <= ev_note_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            rel_found_q   <= rel_found_d;
            rel_idx_q     <= rel_idx_d;
            rel_age_q     <= rel_age_d;
            act_found_q   <= act_found_d;
            act_idx_q     <= act_idx_d;
            act_age_q     <= act_age_d;
            gate_q        <= gate_d;
            vstate_q      <= vstate_d;
            vnote_q       <= vnote_d;
            age_q         <= age_d;
            cnt_q         <= cnt_d;
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus random
// traffic, compared every cycle against an event-level reference model.
module tb_voice_allocator;
    localparam int NV    = 4;
    localparam int REL_C = 16;
    localparam int AB    = 5;
    localparam int AMAX  = (1 << AB) - 1;

    typedef enum int {M_FREE, M_ACT, M_REL} mstate_e;

    logic            clk = 1'b0;
    logic            rst;
    logic            note_valid;
    logic            note_ready;
    logic            note_on;
    logic [6:0]      note_number;
    logic            all_notes_off;
    logic [NV-1:0]   voice_gate;
    logic [8*NV-1:0] voice_note;
    logic            busy;

    voice_allocator #(.NUM_VOICES(NV), .RELEASE_CYCLES(REL_C), .AGE_BITS(AB)) dut (
        .clk(clk), .rst(rst), .note_valid(note_valid), .note_ready(note_ready),
        .note_on(note_on), .note_number(note_number), .all_notes_off(all_notes_off),
        .voice_gate(voice_gate), .voice_note(voice_note), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: voice table plus "edges since accept" (-1 when idle).
    mstate_e m_state [NV];
    int      m_note  [NV];
    int      m_age   [NV];
    int      m_cnt   [NV];
    bit      m_gate  [NV];
    mstate_e snap_state [NV];
    int      snap_note  [NV];
    int      snap_age   [NV];
    int      m_phase = -1;
    int      m_tgt;
    bit      ev_on;
    int      ev_note;
    bit      m_accepted;
    bit      model_live = 0;

    function automatic bit m_ready();
        return (m_phase == -1) && !all_notes_off && !rst;
    endfunction

    function automatic int pick();
        int a = -1, b = -1, c = -1, d = -1;
        for (int i = 0; i < NV; i++) begin
            if (a < 0 && snap_note[i] == ev_note &&
                (snap_state[i] == M_ACT || (ev_on && snap_state[i] == M_REL))) a = i;
            if (b < 0 && snap_state[i] == M_FREE) b = i;
            if (snap_state[i] == M_REL && (c < 0 || snap_age[i] > snap_age[c])) c = i;
            if (snap_state[i] == M_ACT && (d < 0 || snap_age[i] > snap_age[d])) d = i;
        end
        if (!ev_on || a >= 0) return a;
        if (b >= 0) return b;
        if (c >= 0) return c;
        return d;
    endfunction

    task automatic model_step();
        mstate_e n_state [NV];
        int      n_age   [NV];
        int      n_cnt   [NV];
        int      n_note  [NV];
        bit      n_gate  [NV];
        int      t;
        m_accepted = 0;
        if (rst) begin
            for (int i = 0; i < NV; i++) begin
                m_state[i] = M_FREE; m_note[i] = 0; m_age[i] = AMAX; m_cnt[i] = 0; m_gate[i] = 0;
            end
            m_phase    = -1;
            model_live = 1;
            return;
        end
        n_state = m_state; n_age = m_age; n_cnt = m_cnt; n_note = m_note; n_gate = m_gate;
        for (int i = 0; i < NV; i++) begin
            if (m_state[i] != M_FREE) n_age[i] = (m_age[i] < AMAX) ? m_age[i] + 1 : AMAX;
            if (m_state[i] == M_REL) begin
                n_cnt[i] = m_cnt[i] - 1;
                if (n_cnt[i] == 0) n_state[i] = M_FREE;
            end
        end
        if (m_phase == -1) begin
            if (all_notes_off) begin
                for (int i = 0; i < NV; i++) begin
                    if (m_state[i] == M_ACT) begin
                        n_state[i] = M_REL; n_gate[i] = 0; n_cnt[i] = REL_C;
                    end
                end
            end else if (note_valid) begin
                ev_on = note_on; ev_note = int'(note_number); m_phase = 0; m_accepted = 1;
            end
        end else if (m_phase < NV) begin
            snap_state[m_phase] = m_state[m_phase];
            snap_note[m_phase]  = m_note[m_phase];
            snap_age[m_phase]   = m_age[m_phase];
            m_phase++;
        end else if (m_phase == NV) begin
            t = pick();
            if (ev_on) begin
                n_state[t] = M_ACT; n_note[t] = ev_note; n_gate[t] = 0; n_age[t] = 0; n_cnt[t] = 0;
                m_tgt = t; m_phase = NV + 1;
            end else begin
                if (t >= 0) begin
                    n_state[t] = M_REL; n_gate[t] = 0; n_cnt[t] = REL_C;
                end
                m_phase = -1;
            end
        end else begin
            n_gate[m_tgt] = 1;
            m_phase = -1;
        end
        m_state = n_state; m_age = n_age; m_cnt = n_cnt; m_note = n_note; m_gate = n_gate;
    endtask

    task automatic compare_all();
        logic [NV-1:0]   eg;
        logic [8*NV-1:0] en;
        if (!model_live) return;
        for (int i = 0; i < NV; i++) begin
            eg[i]        = m_gate[i];
            en[8*i +: 8] = {1'b0, 7'(m_note[i])};
        end
        check("voice_gate", voice_gate, eg);
        check("voice_note", voice_note, en);
        check("note_ready", note_ready, m_ready());
        check("busy", busy, m_phase != -1);
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic tick();
        #1;
        compare_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic send(input bit on, input int num);
        int guard = 0;
        note_valid  = 1'b1;
        note_on     = on;
        note_number = 7'(num);
        do begin
            tick();
            guard++;
        end while (!m_accepted && guard < 64);
        note_valid = 1'b0;
        check("event_accepted", m_accepted, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit pend = 0;
        rst = 1'b1; note_valid = 1'b0; note_on = 1'b0; note_number = '0; all_notes_off = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        check("reset_gate", voice_gate, 0);
        check("reset_note", voice_note, 0);
        check("reset_busy", busy, 0);
        #1 check("reset_ready", note_ready, 1);

        // Note-on 60: note and gate-low at edge 5, gate high at edge 6, ready for edge 7.
        send(1, 60);
        repeat (4) tick();
        check("n60_scan_busy", busy, 1);
        check("n60_scan_gate", voice_gate, 4'b0000);
        tick();
        check("n60_note", voice_note[7:0], 8'd60);
        check("n60_gate_low", voice_gate, 4'b0000);
        tick();
        check("n60_gate_high", voice_gate, 4'b0001);
        #1 check("n60_ready_back", note_ready, 1);

        send(1, 62); repeat (6) tick();
        send(1, 64); repeat (6) tick();
        send(1, 65); repeat (6) tick();
        check("fill_gate", voice_gate, 4'b1111);
        check("fill_note", voice_note, {8'd65, 8'd64, 8'd62, 8'd60});

        // Steal of the oldest active voice.
        send(1, 67); repeat (5) tick();
        check("steal_gate_low", voice_gate, 4'b1110);
        check("steal_note", voice_note, {8'd65, 8'd64, 8'd62, 8'd67});
        tick();
        check("steal_gate_high", voice_gate, 4'b1111);

        // Note-off 62, then note-on 70 while voice 1 is still releasing.
        send(0, 62); repeat (5) tick();
        check("off62_gate", voice_gate, 4'b1101);
        check("off62_idle", busy, 0);
        repeat (8) tick();
        send(1, 70); repeat (6) tick();
        check("steal_rel_note", voice_note[15:8], 8'd70);
        check("steal_rel_gate", voice_gate, 4'b1111);

        // Release, let it expire, note-on 70 lands on the now-free voice 1.
        send(0, 70); repeat (30) tick();
        send(1, 70); repeat (6) tick();
        check("free_note", voice_note, {8'd65, 8'd64, 8'd70, 8'd67});
        check("free_gate", voice_gate, 4'b1111);

        // Retrigger of 64 on voice 2.
        send(1, 64); repeat (5) tick();
        check("retrig_gate_low", voice_gate, 4'b1011);
        check("retrig_note", voice_note, {8'd65, 8'd64, 8'd70, 8'd67});
        tick();
        check("retrig_gate_high", voice_gate, 4'b1111);

        // Unmatched note-off is dropped.
        send(0, 99); repeat (5) tick();
        check("off99_idle", busy, 0);
        check("off99_gate", voice_gate, 4'b1111);

        // all_notes_off wins over a simultaneous event; event accepted next cycle.
        all_notes_off = 1'b1; note_valid = 1'b1; note_on = 1'b1; note_number = 7'd72;
        #1 check("anoff_ready", note_ready, 0);
        tick();
        all_notes_off = 1'b0;
        check("anoff_gate", voice_gate, 4'b0000);
        check("anoff_busy", busy, 0);
        tick();
        note_valid = 1'b0;
        check("anoff_accept_next", busy, 1);
        repeat (6) tick();

        // Reset during SCAN loses the event.
        send(1, 50); repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_gate", voice_gate, 0);
        check("midrst_note", voice_note, 0);
        check("midrst_busy", busy, 0);
        repeat (10) tick();
        check("midrst_lost_gate", voice_gate, 0);

        // Random traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst           = ($urandom_range(0, 199) == 0);
            all_notes_off = ($urandom_range(0, 59) == 0);
            if (!pend && $urandom_range(0, 3) == 0) begin
                pend        = 1;
                note_on     = ($urandom_range(0, 2) != 0);
                note_number = ($urandom_range(0, 15) == 0) ? 7'd99 : 7'(58 + $urandom_range(0, 7));
            end else if (!pend) begin
                note_on     = 1'($urandom);
                note_number = 7'($urandom);
            end
            note_valid = pend;
            tick();
            if (m_accepted) pend = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
